// File: rtl/cache_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the MEM-stage cache controller.
package cache_pkg;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] LB = 6'b100000;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SB = 6'b101000;

  typedef enum logic [1:0] {
    LOOKUP  = 2'd0,
    WB      = 2'd1,
    REFILL  = 2'd2,
    NOALLOC = 2'd3
  } state_e;

  function automatic logic is_memop(input logic [5:0] op);
    return (op == LW) || (op == LB) || (op == SW) || (op == SB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SW) || (op == SB);
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    return (op == LB) || (op == SB);
  endfunction

  // Byte stores touch one lane, word stores all four.
  function automatic logic [3:0] lane_en(input logic byte_op, input logic [1:0] ab);
    return byte_op ? (4'b0001 << ab) : 4'hF;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Cycle-within-beat and beat-within-line counters for write-back and refill sequencing.
module cache_beat_counter #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned LINE_WORDS  = 4,
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1,
  localparam int unsigned WI = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic [WI-1:0] beat,
  output logic          last_cyc,
  output logic          last_beat
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WI-1:0] beat_q, beat_d;

  assign cnt       = cnt_q;
  assign beat      = beat_q;
  assign last_cyc  = (cnt_q == CW'(MEM_LATENCY - 1));
  assign last_beat = (beat_q == WI'(LINE_WORDS - 1));

  always_comb begin
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (clear) begin
      cnt_d  = '0;
      beat_d = '0;
    end else if (last_cyc) begin
      cnt_d  = '0;
      beat_d = last_beat ? '0 : beat_q + WI'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/cache_line_ctrl.sv
// Write-back cache controller FSM for the MEM stage: one-cycle hits, victim write-back,
// beat-wise line refill with replay, and optional write-around for store misses.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned MEM_LATENCY    = 4,
  parameter int unsigned WRITE_ALLOCATE = 1,
  localparam int unsigned WI = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          valid,
  input  logic [5:0]    opcode,
  input  logic [1:0]    addr_byte,
  input  logic          hit,
  input  logic          dirty,
  output logic          stall,
  output logic          reg_write_enable,
  output logic          cache_we,
  output logic          cache_in_select,
  output logic [3:0]    cache_byte_en,
  output logic          set_dirty,
  output logic          set_valid,
  output logic          clear_dirty,
  output logic          mem_we,
  output logic          mem_in_select,
  output logic [3:0]    mem_byte_en,
  output logic [WI-1:0] word_idx
);

  state_e        state_q, state_d;
  logic          is_store_q, is_store_d;
  logic          is_byte_q, is_byte_d;
  logic [1:0]    addr_byte_q, addr_byte_d;
  logic [CW-1:0] cnt;
  logic [WI-1:0] beat;
  logic          last_cyc, last_beat;
  logic          cnt_clear;

  // Counters idle in LOOKUP and restart on every state transition.
  assign cnt_clear = (state_d != state_q) || (state_q == LOOKUP);

  cache_beat_counter #(
    .MEM_LATENCY (MEM_LATENCY),
    .LINE_WORDS  (LINE_WORDS)
  ) u_beat_counter (
    .clk       (clk),
    .rst_b     (rst_b),
    .clear     (cnt_clear),
    .cnt       (cnt),
    .beat      (beat),
    .last_cyc  (last_cyc),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d          = state_q;
    is_store_d       = is_store_q;
    is_byte_d        = is_byte_q;
    addr_byte_d      = addr_byte_q;
    stall            = 1'b0;
    reg_write_enable = 1'b0;
    cache_we         = 1'b0;
    cache_in_select  = 1'b0;
    cache_byte_en    = 4'h0;
    set_dirty        = 1'b0;
    set_valid        = 1'b0;
    clear_dirty      = 1'b0;
    mem_we           = 1'b0;
    mem_in_select    = 1'b0;
    mem_byte_en      = 4'h0;
    word_idx         = '0;

    unique case (state_q)
      LOOKUP: begin
        if (valid && is_memop(opcode)) begin
          if (hit) begin
            if (is_store(opcode)) begin
              cache_we        = 1'b1;
              cache_in_select = 1'b1;
              cache_byte_en   = lane_en(is_byte(opcode), addr_byte);
              set_dirty       = 1'b1;
            end else begin
              reg_write_enable = 1'b1;
            end
          end else begin
            stall       = 1'b1;
            is_store_d  = is_store(opcode);
            is_byte_d   = is_byte(opcode);
            addr_byte_d = addr_byte;
            if (dirty)
              state_d = WB;
            else if (is_store(opcode) && (WRITE_ALLOCATE == 0))
              state_d = NOALLOC;
            else
              state_d = REFILL;
          end
        end
      end

      WB: begin
        stall         = 1'b1;
        mem_in_select = 1'b1;
        word_idx      = beat;
        if (cnt == '0) begin
          mem_we      = 1'b1;
          mem_byte_en = 4'hF;
        end
        if (last_cyc && last_beat)
          state_d = (is_store_q && (WRITE_ALLOCATE == 0)) ? NOALLOC : REFILL;
      end

      REFILL: begin
        stall    = 1'b1;
        word_idx = beat;
        if (last_cyc) begin
          cache_we      = 1'b1;
          cache_byte_en = 4'hF;
          if (last_beat) begin
            set_valid   = 1'b1;
            clear_dirty = 1'b1;
            state_d     = LOOKUP;
          end
        end
      end

      NOALLOC: begin
        stall = !last_cyc;
        if (cnt == '0) begin
          mem_we      = 1'b1;
          mem_byte_en = lane_en(is_byte_q, addr_byte_q);
        end
        if (last_cyc)
          state_d = LOOKUP;
      end

      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= LOOKUP;
      is_store_q  <= 1'b0;
      is_byte_q   <= 1'b0;
      addr_byte_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      is_byte_q   <= is_byte_d;
      addr_byte_q <= addr_byte_d;
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench for cache_line_ctrl: driver queues hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against one of three parameter variants.
module tb_cache_line_ctrl;
  import cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       valid;
  logic [5:0] opcode;
  logic [1:0] addr_byte;
  logic       hit;
  logic       dirty;

  // {stall, rwe, cache_we, cache_in_sel, cache_be[3:0], set_dirty, set_valid, clear_dirty,
  //  mem_we, mem_in_sel, mem_be[3:0], word_idx[1:0]}
  wire [18:0] act_a, act_b, act_c;

  logic [18:0] exp_q[$];
  int          dut_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [18:0] Z = 19'd0;

  always #5 clk = ~clk;

  cache_line_ctrl #(.LINE_WORDS(4), .MEM_LATENCY(4), .WRITE_ALLOCATE(1)) dut_a (
    .clk(clk), .rst_b(rst_b), .valid(valid), .opcode(opcode), .addr_byte(addr_byte),
    .hit(hit), .dirty(dirty), .stall(act_a[18]), .reg_write_enable(act_a[17]),
    .cache_we(act_a[16]), .cache_in_select(act_a[15]), .cache_byte_en(act_a[14:11]),
    .set_dirty(act_a[10]), .set_valid(act_a[9]), .clear_dirty(act_a[8]), .mem_we(act_a[7]),
    .mem_in_select(act_a[6]), .mem_byte_en(act_a[5:2]), .word_idx(act_a[1:0]));

  cache_line_ctrl #(.LINE_WORDS(4), .MEM_LATENCY(4), .WRITE_ALLOCATE(0)) dut_b (
    .clk(clk), .rst_b(rst_b), .valid(valid), .opcode(opcode), .addr_byte(addr_byte),
    .hit(hit), .dirty(dirty), .stall(act_b[18]), .reg_write_enable(act_b[17]),
    .cache_we(act_b[16]), .cache_in_select(act_b[15]), .cache_byte_en(act_b[14:11]),
    .set_dirty(act_b[10]), .set_valid(act_b[9]), .clear_dirty(act_b[8]), .mem_we(act_b[7]),
    .mem_in_select(act_b[6]), .mem_byte_en(act_b[5:2]), .word_idx(act_b[1:0]));

  cache_line_ctrl #(.LINE_WORDS(1), .MEM_LATENCY(1), .WRITE_ALLOCATE(1)) dut_c (
    .clk(clk), .rst_b(rst_b), .valid(valid), .opcode(opcode), .addr_byte(addr_byte),
    .hit(hit), .dirty(dirty), .stall(act_c[18]), .reg_write_enable(act_c[17]),
    .cache_we(act_c[16]), .cache_in_select(act_c[15]), .cache_byte_en(act_c[14:11]),
    .set_dirty(act_c[10]), .set_valid(act_c[9]), .clear_dirty(act_c[8]), .mem_we(act_c[7]),
    .mem_in_select(act_c[6]), .mem_byte_en(act_c[5:2]), .word_idx(act_c[0]));
  assign act_c[1] = 1'b0;

  function automatic logic [18:0] ev(input logic st, rw, cw, ci, input logic [3:0] cb,
                                     input logic sd, sv, cd, mw, mi, input logic [3:0] mb,
                                     input logic [1:0] wi);
    return {st, rw, cw, ci, cb, sd, sv, cd, mw, mi, mb, wi};
  endfunction

  // One clock of stimulus: queue the expectation for the current inputs, then advance.
  task automatic cyc(input int d, input logic [18:0] e, input string n);
    exp_q.push_back(e);
    dut_q.push_back(d);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] ab,
                       input logic h, input logic dt);
    valid = v; opcode = op; addr_byte = ab; hit = h; dirty = dt;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [18:0] e, a;
      int          d;
      string       n;
      e = exp_q.pop_front();
      d = dut_q.pop_front();
      n = name_q.pop_front();
      a = (d == 0) ? act_a : (d == 1) ? act_b : act_c;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, a, e);
      end
    end
  end

  initial begin
    rst_b = 1'b0;
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cyc(0, Z, "reset_a");
    cyc(1, Z, "reset_b");
    cyc(2, Z, "reset_c");
    rst_b = 1'b1;

    // Hits and non-memop traffic.
    drive(1'b1, LW, 2'd0, 1'b1, 1'b0);
    cyc(0, ev(0,1,0,0,4'h0,0,0,0,0,0,4'h0,0), "lw_hit");
    drive(1'b1, SB, 2'd2, 1'b1, 1'b0);
    cyc(0, ev(0,0,1,1,4'b0100,1,0,0,0,0,4'h0,0), "sb_hit_ab2");
    drive(1'b1, SW, 2'd3, 1'b1, 1'b1);
    cyc(0, ev(0,0,1,1,4'hF,1,0,0,0,0,4'h0,0), "sw_hit");
    drive(1'b1, LB, 2'd1, 1'b1, 1'b0);
    cyc(2, ev(0,1,0,0,4'h0,0,0,0,0,0,4'h0,0), "lb_hit_c");
    drive(1'b1, 6'b000000, 2'd0, 1'b0, 1'b1);
    cyc(0, Z, "non_memop");
    drive(1'b0, LW, 2'd0, 1'b0, 1'b1);
    cyc(0, Z, "invalid_lw");

    // Clean LW miss: 1 lookup + 16 refill stall cycles, then replay hit.
    drive(1'b1, LW, 2'd0, 1'b0, 1'b0);
    cyc(0, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "lw_miss_lookup");
    drive(1'b0, SB, 2'd3, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++)
      cyc(0, ev(1'b1, 1'b0, (k % 4 == 3), 1'b0, (k % 4 == 3) ? 4'hF : 4'h0, 1'b0,
                (k == 15), (k == 15), 1'b0, 1'b0, 4'h0, 2'(k / 4)),
          $sformatf("lw_refill_%0d", k));
    drive(1'b1, LW, 2'd0, 1'b1, 1'b0);
    cyc(0, ev(0,1,0,0,4'h0,0,0,0,0,0,4'h0,0), "lw_replay");

    // Dirty SW miss: write-back, refill, replay store.
    do_reset();
    drive(1'b1, SW, 2'd0, 1'b0, 1'b1);
    cyc(0, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "sw_miss_lookup");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      cyc(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, (k % 4 == 0), 1'b1,
                (k % 4 == 0) ? 4'hF : 4'h0, 2'(k / 4)), $sformatf("sw_wb_%0d", k));
    for (int k = 0; k < 16; k++)
      cyc(0, ev(1'b1, 1'b0, (k % 4 == 3), 1'b0, (k % 4 == 3) ? 4'hF : 4'h0, 1'b0,
                (k == 15), (k == 15), 1'b0, 1'b0, 4'h0, 2'(k / 4)),
          $sformatf("sw_refill_%0d", k));
    drive(1'b1, SW, 2'd0, 1'b1, 1'b0);
    cyc(0, ev(0,0,1,1,4'hF,1,0,0,0,0,4'h0,0), "sw_replay");

    // Write-around: clean SB miss goes straight to NOALLOC.
    do_reset();
    drive(1'b1, SB, 2'd1, 1'b0, 1'b0);
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sb_lookup");
    drive(1'b0, LW, 2'd3, 1'b1, 1'b1);
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,1,0,4'b0010,0), "na_sb_memwe");
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sb_c1");
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sb_c2");
    cyc(1, Z, "na_sb_release");
    cyc(1, Z, "na_sb_idle");

    // Write-around with dirty victim: WB then NOALLOC for the word store.
    drive(1'b1, SW, 2'd2, 1'b0, 1'b1);
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sw_lookup");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      cyc(1, ev(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, (k % 4 == 0), 1'b1,
                (k % 4 == 0) ? 4'hF : 4'h0, 2'(k / 4)), $sformatf("na_sw_wb_%0d", k));
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,1,0,4'hF,0), "na_sw_memwe");
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sw_c1");
    cyc(1, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "na_sw_c2");
    cyc(1, Z, "na_sw_release");

    // Reset during WB beat 2 aborts the miss.
    do_reset();
    drive(1'b1, SW, 2'd0, 1'b0, 1'b1);
    cyc(0, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "abort_lookup");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, (k % 4 == 0), 1'b1,
                (k % 4 == 0) ? 4'hF : 4'h0, 2'(k / 4)), $sformatf("abort_wb_%0d", k));
    rst_b = 1'b0;
    cyc(0, ev(1,0,0,0,4'h0,0,0,0,1,1,4'hF,2), "abort_wb_beat2");
    rst_b = 1'b1;
    for (int k = 0; k < 6; k++)
      cyc(0, Z, $sformatf("abort_idle_%0d", k));

    // MEM_LATENCY=1, LINE_WORDS=1 variant.
    drive(1'b1, LW, 2'd0, 1'b0, 1'b0);
    cyc(2, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "ml1_lw_lookup");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    cyc(2, ev(1,0,1,0,4'hF,0,1,1,0,0,4'h0,0), "ml1_lw_refill");
    drive(1'b1, LW, 2'd0, 1'b1, 1'b0);
    cyc(2, ev(0,1,0,0,4'h0,0,0,0,0,0,4'h0,0), "ml1_lw_replay");
    drive(1'b1, SB, 2'd3, 1'b0, 1'b1);
    cyc(2, ev(1,0,0,0,4'h0,0,0,0,0,0,4'h0,0), "ml1_sb_lookup");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
    cyc(2, ev(1,0,0,0,4'h0,0,0,0,1,1,4'hF,0), "ml1_sb_wb");
    cyc(2, ev(1,0,1,0,4'hF,0,1,1,0,0,4'h0,0), "ml1_sb_refill");
    drive(1'b1, SB, 2'd3, 1'b1, 1'b0);
    cyc(2, ev(0,0,1,1,4'b1000,1,0,0,0,0,4'h0,0), "ml1_sb_replay");
    drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
